// File: rtl/motion_executor.sv
// Timed motor-drive sequencer: turns front/turn requests into forward steps or right turns plus settle.
// Optional emergency stop (estop input, HALT state) is enabled with `define MOTION_ESTOP_EN.
module motion_executor #(
  parameter int unsigned FWD_CYCLES    = 8,
  parameter int unsigned TURN_CYCLES   = 12,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned CNT_W         = 8,
  parameter int unsigned STEP_W        = 16
) (
  input  logic              clk,
  input  logic              reset,
`ifdef MOTION_ESTOP_EN
  input  logic              estop,
`endif
  input  logic              front,
  input  logic              turn,
  output logic [1:0]        motor_left,
  output logic [1:0]        motor_right,
  output logic              busy,
  output logic              done,
  output logic              cmd_err,
  output logic [STEP_W-1:0] step_count
);

  localparam logic [1:0] M_STOP = 2'b00;
  localparam logic [1:0] M_FWD  = 2'b01;
  localparam logic [1:0] M_REV  = 2'b10;

  localparam logic [CNT_W-1:0] FWD_LOAD    = CNT_W'(FWD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TURN_LOAD   = CNT_W'(TURN_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FWD,
    S_TURN,
    S_SETTLE
`ifdef MOTION_ESTOP_EN
    , S_HALT
`endif
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      motor_left  <= M_STOP;
      motor_right <= M_STOP;
      done        <= 1'b0;
      cmd_err     <= 1'b0;
      step_count  <= '0;
    end
`ifdef MOTION_ESTOP_EN
    else if (estop) begin
      state       <= S_HALT;
      cnt         <= '0;
      motor_left  <= M_STOP;
      motor_right <= M_STOP;
      done        <= 1'b0;
    end
`endif
    else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          // Conflicting request resolves to a turn: never drive forward into a wall.
          if (turn) begin
            state       <= S_TURN;
            cnt         <= TURN_LOAD;
            motor_left  <= M_FWD;
            motor_right <= M_REV;
            if (front) cmd_err <= 1'b1;
          end else if (front) begin
            state       <= S_FWD;
            cnt         <= FWD_LOAD;
            motor_left  <= M_FWD;
            motor_right <= M_FWD;
          end
        end
        S_FWD: begin
          if (cnt == '0) begin
            state       <= S_SETTLE;
            cnt         <= SETTLE_LOAD;
            motor_left  <= M_STOP;
            motor_right <= M_STOP;
            step_count  <= step_count + STEP_W'(1);
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_TURN: begin
          if (cnt == '0) begin
            state       <= S_SETTLE;
            cnt         <= SETTLE_LOAD;
            motor_left  <= M_STOP;
            motor_right <= M_STOP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_SETTLE: begin
          if (cnt == '0) begin
            state <= S_IDLE;
            done  <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
`ifdef MOTION_ESTOP_EN
        S_HALT: state <= S_IDLE;
`endif
        default: begin
          state       <= S_IDLE;
          cnt         <= '0;
          motor_left  <= M_STOP;
          motor_right <= M_STOP;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_motion_executor.sv
// Self-checking bench for motion_executor: directed steps plus random requests against a schedule-based model.
// A second instance with STEP_W=4 shares all inputs to exercise step_count wrap.
module tb_motion_executor;

  localparam int FWD = 8;
  localparam int TRN = 12;
  localparam int SET = 2;

  logic        clk = 1'b0;
  logic        reset, front, turn;
`ifdef MOTION_ESTOP_EN
  logic        estop;
`endif
  logic [1:0]  motor_left, motor_right, motor_left4, motor_right4;
  logic        busy, done, cmd_err, busy4, done4, cmd_err4;
  logic [15:0] step_count;
  logic [3:0]  step_count4;

  int checks = 0;
  int errors = 0;

  motion_executor #(.FWD_CYCLES(FWD), .TURN_CYCLES(TRN), .SETTLE_CYCLES(SET)) dut (
    .clk(clk), .reset(reset),
`ifdef MOTION_ESTOP_EN
    .estop(estop),
`endif
    .front(front), .turn(turn),
    .motor_left(motor_left), .motor_right(motor_right),
    .busy(busy), .done(done), .cmd_err(cmd_err), .step_count(step_count)
  );

  motion_executor #(.STEP_W(4)) dut4 (
    .clk(clk), .reset(reset),
`ifdef MOTION_ESTOP_EN
    .estop(estop),
`endif
    .front(front), .turn(turn),
    .motor_left(motor_left4), .motor_right(motor_right4),
    .busy(busy4), .done(done4), .cmd_err(cmd_err4), .step_count(step_count4)
  );

  always #5 clk = ~clk;

  // Model: a move is a schedule keyed on the edge it was accepted at;
  // offset j = edge - start gives drive (j<D), settle (D<=j<D+S), then done.
  int          n = 0;
  int          m_start = 0;
  bit          m_active = 0, m_halt = 0, m_err = 0, m_done = 0, m_is_fwd = 0;
  int unsigned m_steps = 0;

  function automatic int drive_len();
    return m_is_fwd ? FWD : TRN;
  endfunction

  task automatic model_edge(input bit r, input bit f, input bit t, input bit e);
    int j;
    n++;
    m_done = 0;
    if (r) begin
      m_active = 0; m_halt = 0; m_err = 0; m_steps = 0;
    end else if (e) begin
      m_active = 0; m_halt = 1;
    end else if (m_halt) begin
      m_halt = 0;
    end else if (m_active) begin
      j = n - m_start;
      if (m_is_fwd && j == drive_len()) m_steps++;
      if (j == drive_len() + SET) begin
        m_active = 0; m_done = 1;
      end
    end else if (f || t) begin
      m_active = 1; m_start = n; m_is_fwd = f && !t;
      if (f && t) m_err = 1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, n);
    end
  endtask

  task automatic check_all();
    logic [1:0] el, er;
    el = 2'b00; er = 2'b00;
    if (m_active && (n - m_start) < drive_len()) begin
      el = 2'b01;
      er = m_is_fwd ? 2'b01 : 2'b10;
    end
    chk("motor_left",  {30'd0, motor_left},  {30'd0, el});
    chk("motor_right", {30'd0, motor_right}, {30'd0, er});
    chk("busy",        {31'd0, busy},        {31'd0, (m_active || m_halt)});
    chk("done",        {31'd0, done},        {31'd0, m_done});
    chk("cmd_err",     {31'd0, cmd_err},     {31'd0, m_err});
    chk("step_count",  {16'd0, step_count},  {16'd0, m_steps[15:0]});
    chk("step_count4", {28'd0, step_count4}, {28'd0, m_steps[3:0]});
  endtask

  task automatic tick(input bit r, input bit f, input bit t, input bit e);
    reset = r; front = f; turn = t;
`ifdef MOTION_ESTOP_EN
    estop = e;
`endif
    @(posedge clk);
    model_edge(r, f, t, e);
    #1;
    check_all();
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) tick(0, 0, 0, 0);
  endtask

  initial begin
    bit f, t, r, e;

    // Reset held with front asserted; forward starts right after release.
    tick(1, 1, 0, 0);
    tick(1, 1, 0, 0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_motor", {30'd0, motor_left}, 32'd0);
    tick(0, 1, 0, 0);
    chk("fwd_start", {30'd0, motor_left}, 32'd1);
    idle(12);
    chk("fwd_steps", {16'd0, step_count}, 32'd1);

    // Single turn.
    tick(0, 0, 1, 0);
    idle(14);
    chk("turn_err", {31'd0, cmd_err}, 32'd0);
    chk("turn_steps", {16'd0, step_count}, 32'd1);

    // Conflicting request, then three clean forward moves.
    tick(0, 1, 1, 0);
    chk("conflict_right", {30'd0, motor_right}, 32'd2);
    idle(14);
    for (int k = 0; k < 3; k++) begin
      tick(0, 1, 0, 0);
      idle(10);
    end
    chk("err_sticky", {31'd0, cmd_err}, 32'd1);
    chk("steps_4", {16'd0, step_count}, 32'd4);

    // Reset four cycles into a forward move.
    tick(0, 1, 0, 0);
    idle(3);
    tick(1, 0, 0, 0);
    chk("midrst_motor", {30'd0, motor_left}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    idle(3);

    // Held front: 16 moves, turn toggled only mid-move; narrow counter wraps.
    for (int i = 0; i < 16 * 11; i++) begin
      t = ((i % 11) != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      tick(0, 1, t, 0);
    end
    chk("held_steps", {16'd0, step_count}, 32'd16);
    chk("wrap4", {28'd0, step_count4}, 32'd0);
    chk("held_err", {31'd0, cmd_err}, 32'd0);
    idle(12);

`ifdef MOTION_ESTOP_EN
    // Emergency stop mid-turn, then release and a fresh forward move.
    tick(0, 0, 1, 0);
    idle(3);
    tick(0, 1, 0, 1);
    chk("estop_motor", {30'd0, motor_left}, 32'd0);
    chk("estop_busy", {31'd0, busy}, 32'd1);
    tick(0, 1, 0, 1);
    tick(0, 0, 0, 0);
    chk("halt_exit_busy", {31'd0, busy}, 32'd0);
    chk("halt_exit_done", {31'd0, done}, 32'd0);
    tick(0, 1, 0, 0);
    chk("after_halt_fwd", {30'd0, motor_left}, 32'd1);
    idle(11);
`endif

    // Random requests; conflicting pair only offered while idle.
    for (int i = 0; i < 600; i++) begin
      f = ($urandom_range(0, 3) == 0);
      t = ($urandom_range(0, 4) == 0);
      if (f && t && (m_active || m_halt)) t = 1'b0;
      r = ($urandom_range(0, 79) == 0);
      e = 1'b0;
`ifdef MOTION_ESTOP_EN
      e = ($urandom_range(0, 39) == 0);
`endif
      tick(r, f, t, e);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
